// File: rtl/lc3_execute_pkg.sv
// lc3_pkg: shared LC3 opcodes, control encodings and sign-extension helpers
package lc3_pkg;
  localparam int DW = 16;
  localparam int RAW = 3;
  localparam logic [3:0] OP_BR = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD = 4'b0010;
  localparam logic [3:0] OP_ST = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_RSV} alu_op_t;
  typedef enum logic [1:0] {PC_OFF11, PC_OFF9, PC_OFF6, PC_ZERO} pcsel1_t;
  function automatic logic [DW-1:0] sext5(input logic [4:0] v);
    return {{(DW-5){v[4]}}, v};
  endfunction
  function automatic logic [DW-1:0] sext6(input logic [5:0] v);
    return {{(DW-6){v[5]}}, v};
  endfunction
  function automatic logic [DW-1:0] sext9(input logic [8:0] v);
    return {{(DW-9){v[8]}}, v};
  endfunction
  function automatic logic [DW-1:0] sext11(input logic [10:0] v);
    return {{(DW-11){v[10]}}, v};
  endfunction
endpackage

// File: rtl/lc3_execute_if.sv
// lc3_execute_if: decode-to-execute bundle plus execute stage results
interface lc3_execute_if;
  import lc3_pkg::*;
  logic enable_execute;
  logic [5:0] E_Control;
  logic [1:0] W_Control_in;
  logic Mem_Control_in;
  logic [DW-1:0] IR;
  logic [DW-1:0] npc_in;
  logic [DW-1:0] VSR1;
  logic [DW-1:0] VSR2;
  logic bypass_alu_1;
  logic bypass_alu_2;
  logic bypass_mem_1;
  logic bypass_mem_2;
  logic [DW-1:0] Mem_Bypass_Val;
  logic [DW-1:0] aluout;
  logic [DW-1:0] pcout;
  logic [DW-1:0] M_Data;
  logic [RAW-1:0] dr;
  logic [RAW-1:0] sr1;
  logic [RAW-1:0] sr2;
  logic [DW-1:0] IR_Exec;
  logic [2:0] NZP;
  logic [1:0] W_Control_out;
  logic Mem_Control_out;
  modport master (
    output enable_execute, E_Control, W_Control_in, Mem_Control_in, IR, npc_in, VSR1, VSR2,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val,
    input  aluout, pcout, M_Data, dr, sr1, sr2, IR_Exec, NZP, W_Control_out, Mem_Control_out
  );
  modport slave (
    input  enable_execute, E_Control, W_Control_in, Mem_Control_in, IR, npc_in, VSR1, VSR2,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val,
    output aluout, pcout, M_Data, dr, sr1, sr2, IR_Exec, NZP, W_Control_out, Mem_Control_out
  );
endinterface

// File: rtl/lc3_exec_alu.sv
// lc3_exec_alu: combinational ADD/AND/NOT, reserved encoding yields zero
module lc3_exec_alu
  import lc3_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_t op,
  output logic [DW-1:0] y
);
  // select the operation result; carry out of ADD is dropped
  always_comb
    y = op == ALU_ADD ? a + b :
        op == ALU_AND ? a & b :
        op == ALU_NOT ? ~a : '0;
endmodule

// File: rtl/lc3_execute.sv
// lc3_execute: LC3 execute stage with operand bypass, address adder and result registers
module lc3_execute
  import lc3_pkg::*;
(
  input logic clock,
  input logic reset,
  lc3_execute_if.slave ex
);
  logic [3:0] op;
  logic is_alu, is_st, is_ld;
  alu_op_t alu_ctl;
  pcsel1_t pcsel1;
  logic pcsel2, op2sel;
  logic [DW-1:0] op1, op2, alu_b, alu_y, base, offset, pc_sum;
  logic [RAW-1:0] dr_d;
  logic [2:0] nzp_d;
  assign op = ex.IR[15:12];
  assign is_alu = op == OP_ADD || op == OP_AND || op == OP_NOT;
  assign is_st = op == OP_ST || op == OP_STR || op == OP_STI;
  assign is_ld = op == OP_LD || op == OP_LDR || op == OP_LDI;
  assign alu_ctl = alu_op_t'(ex.E_Control[5:4]);
  assign pcsel1 = pcsel1_t'(ex.E_Control[3:2]);
  assign pcsel2 = ex.E_Control[1];
  assign op2sel = ex.E_Control[0];
  // register-file read addresses and destination/condition decode
  always_comb begin
    ex.sr1 = ex.IR[8:6];
    ex.sr2 = is_alu ? ex.IR[2:0] : is_st ? ex.IR[11:9] : '0;
    dr_d = (is_alu || is_ld || op == OP_LEA) ? ex.IR[11:9] : '0;
    nzp_d = op == OP_BR ? ex.IR[11:9] : op == OP_JMP ? 3'b111 : 3'b000;
  end
  // operand forwarding: the registered ALU result outranks the memory-stage value
  always_comb begin
    op1 = ex.bypass_alu_1 ? ex.aluout : ex.bypass_mem_1 ? ex.Mem_Bypass_Val : ex.VSR1;
    op2 = ex.bypass_alu_2 ? ex.aluout : ex.bypass_mem_2 ? ex.Mem_Bypass_Val : ex.VSR2;
    alu_b = op2sel ? op2 : sext5(ex.IR[4:0]);
  end
  // branch/memory address adder, wrapping modulo 2^16
  always_comb begin
    base = pcsel2 ? ex.npc_in : op1;
    offset = pcsel1 == PC_OFF11 ? sext11(ex.IR[10:0]) :
             pcsel1 == PC_OFF9  ? sext9(ex.IR[8:0]) :
             pcsel1 == PC_OFF6  ? sext6(ex.IR[5:0]) : '0;
    pc_sum = base + offset;
  end
  lc3_exec_alu u_alu (
    .a(op1),
    .b(alu_b),
    .op(alu_ctl),
    .y(alu_y)
  );
  // stage register bank: clear on reset, capture when enabled, otherwise hold
  always_ff @(posedge clock)
    if (!reset) begin
      ex.aluout <= '0;
      ex.pcout <= '0;
      ex.M_Data <= '0;
      ex.dr <= '0;
      ex.IR_Exec <= '0;
      ex.NZP <= '0;
      ex.W_Control_out <= '0;
      ex.Mem_Control_out <= 1'b0;
    end else if (ex.enable_execute) begin
      ex.aluout <= op == OP_LEA ? pc_sum : alu_y;
      ex.pcout <= pc_sum;
      ex.M_Data <= op2;
      ex.dr <= dr_d;
      ex.IR_Exec <= ex.IR;
      ex.NZP <= nzp_d;
      ex.W_Control_out <= ex.W_Control_in;
      ex.Mem_Control_out <= ex.Mem_Control_in;
    end
endmodule

// File: tb/tb_lc3_execute.sv
// tb_lc3_execute: directed vectors with hand-computed results for the execute stage
module tb_lc3_execute;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  lc3_execute_if bus ();
  lc3_execute dut (
    .clock(clock),
    .reset(reset),
    .ex(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic clr();
    bus.enable_execute = 1'b1;
    bus.E_Control = '0;
    bus.W_Control_in = '0;
    bus.Mem_Control_in = 1'b0;
    bus.IR = '0;
    bus.npc_in = '0;
    bus.VSR1 = '0;
    bus.VSR2 = '0;
    bus.bypass_alu_1 = 1'b0;
    bus.bypass_alu_2 = 1'b0;
    bus.bypass_mem_1 = 1'b0;
    bus.bypass_mem_2 = 1'b0;
    bus.Mem_Bypass_Val = '0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_aluout"}, bus.aluout, 16'h0);
    chk({tag, "_pcout"}, bus.pcout, 16'h0);
    chk({tag, "_mdata"}, bus.M_Data, 16'h0);
    chk({tag, "_dr"}, 16'(bus.dr), 16'h0);
    chk({tag, "_ir"}, bus.IR_Exec, 16'h0);
    chk({tag, "_nzp"}, 16'(bus.NZP), 16'h0);
    chk({tag, "_wctl"}, 16'(bus.W_Control_out), 16'h0);
    chk({tag, "_mctl"}, 16'(bus.Mem_Control_out), 16'h0);
  endtask
  initial begin
    clr();
    bus.IR = 16'h1642; bus.E_Control = 6'b000001; bus.VSR1 = 16'd5; bus.VSR2 = 16'd7;
    bus.W_Control_in = 2'b10; bus.Mem_Control_in = 1'b1;
    tick(); tick();
    chk_zero("rst");
    chk("rst_sr1", 16'(bus.sr1), 16'd1);
    chk("rst_sr2", 16'(bus.sr2), 16'd2);
    reset = 1'b1;
    tick();
    chk("add_aluout", bus.aluout, 16'd12);
    chk("add_dr", 16'(bus.dr), 16'd3);
    chk("add_nzp", 16'(bus.NZP), 16'd0);
    chk("add_mdata", bus.M_Data, 16'd7);
    chk("add_pcout", bus.pcout, 16'hFE47);
    chk("add_ir", bus.IR_Exec, 16'h1642);
    chk("add_wctl", 16'(bus.W_Control_out), 16'd2);
    chk("add_mctl", 16'(bus.Mem_Control_out), 16'd1);
    bus.bypass_alu_1 = 1'b1; bus.bypass_mem_1 = 1'b1; bus.Mem_Bypass_Val = 16'd99; bus.VSR2 = 16'd1;
    tick();
    chk("byp_prio_aluout", bus.aluout, 16'd13);
    chk("byp_prio_mdata", bus.M_Data, 16'd1);
    bus.bypass_alu_1 = 1'b0;
    tick();
    chk("byp_mem1_aluout", bus.aluout, 16'd100);
    bus.bypass_mem_1 = 1'b0; bus.bypass_alu_2 = 1'b1;
    tick();
    chk("byp_alu2_aluout", bus.aluout, 16'd105);
    chk("byp_alu2_mdata", bus.M_Data, 16'd100);
    clr();
    bus.IR = 16'h1A7F; bus.VSR1 = 16'h0000;
    tick();
    chk("addi_aluout", bus.aluout, 16'hFFFF);
    chk("addi_dr", 16'(bus.dr), 16'd5);
    bus.IR = 16'h5443; bus.E_Control = 6'b010001; bus.VSR1 = 16'h0F0F; bus.VSR2 = 16'h00FF;
    #1;
    chk("and_sr2", 16'(bus.sr2), 16'd3);
    tick();
    chk("and_aluout", bus.aluout, 16'h000F);
    chk("and_dr", 16'(bus.dr), 16'd2);
    bus.IR = 16'h987F; bus.E_Control = 6'b100000; bus.VSR1 = 16'h1234;
    tick();
    chk("not_aluout", bus.aluout, 16'hEDCB);
    chk("not_dr", 16'(bus.dr), 16'd4);
    bus.IR = 16'h1642; bus.E_Control = 6'b110001; bus.VSR1 = 16'd5; bus.VSR2 = 16'd7;
    tick();
    chk("rsv_aluout", bus.aluout, 16'h0);
    clr();
    bus.IR = 16'h0C10; bus.npc_in = 16'h3001; bus.E_Control = 6'b000110;
    #1;
    chk("br_sr2", 16'(bus.sr2), 16'd0);
    tick();
    chk("br_pcout", bus.pcout, 16'h3011);
    chk("br_nzp", 16'(bus.NZP), 16'b110);
    chk("br_dr", 16'(bus.dr), 16'd0);
    chk("br_aluout", bus.aluout, 16'hFFF0);
    bus.IR = 16'h1642; bus.E_Control = 6'b000001; bus.VSR1 = 16'hFFFF; bus.VSR2 = 16'd2;
    tick();
    chk("addwrap_aluout", bus.aluout, 16'd1);
    bus.IR = 16'hEFFF; bus.E_Control = 6'b000110; bus.npc_in = 16'h0000;
    tick();
    chk("lea_pcout", bus.pcout, 16'hFFFF);
    chk("lea_aluout", bus.aluout, 16'hFFFF);
    chk("lea_dr", 16'(bus.dr), 16'd7);
    clr();
    bus.IR = 16'h7685; bus.E_Control = 6'b001000; bus.VSR1 = 16'h4000; bus.VSR2 = 16'hBEEF;
    bus.bypass_mem_2 = 1'b1; bus.Mem_Bypass_Val = 16'hCAFE;
    #1;
    chk("str_sr1", 16'(bus.sr1), 16'd2);
    chk("str_sr2", 16'(bus.sr2), 16'd3);
    tick();
    chk("str_mdata", bus.M_Data, 16'hCAFE);
    chk("str_pcout", bus.pcout, 16'h4005);
    chk("str_dr", 16'(bus.dr), 16'd0);
    chk("str_nzp", 16'(bus.NZP), 16'd0);
    clr();
    bus.IR = 16'hC080; bus.E_Control = 6'b001100; bus.VSR1 = 16'h3000;
    tick();
    chk("jmp_pcout", bus.pcout, 16'h3000);
    chk("jmp_nzp", 16'(bus.NZP), 16'b111);
    bus.IR = 16'h6AFE; bus.E_Control = 6'b001000; bus.VSR1 = 16'h2000;
    #1;
    chk("ldr_sr1", 16'(bus.sr1), 16'd3);
    chk("ldr_sr2", 16'(bus.sr2), 16'd0);
    tick();
    chk("ldr_pcout", bus.pcout, 16'h1FFE);
    chk("ldr_aluout", bus.aluout, 16'h1FFE);
    chk("ldr_dr", 16'(bus.dr), 16'd5);
    chk("ldr_nzp", 16'(bus.NZP), 16'd0);
    bus.enable_execute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.IR = 16'h1642 + 16'(i); bus.E_Control = 6'b000001; bus.VSR1 = 16'(i * 11); bus.VSR2 = 16'd9;
      bus.W_Control_in = 2'b11; bus.Mem_Control_in = 1'b1;
      tick();
      chk("hold_aluout", bus.aluout, 16'h1FFE);
      chk("hold_pcout", bus.pcout, 16'h1FFE);
      chk("hold_dr", 16'(bus.dr), 16'd5);
      chk("hold_ir", bus.IR_Exec, 16'h6AFE);
      chk("hold_wctl", 16'(bus.W_Control_out), 16'd0);
    end
    reset = 1'b0;
    tick();
    chk_zero("midrst");
    reset = 1'b1;
    clr();
    bus.IR = 16'h1642; bus.E_Control = 6'b000001; bus.VSR1 = 16'd50; bus.VSR2 = 16'd7;
    bus.bypass_alu_1 = 1'b1;
    tick();
    chk("postrst_aluout", bus.aluout, 16'd7);
    chk("postrst_dr", 16'(bus.dr), 16'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
